// File: rtl/mem_access_unit_if.sv
// Word-addressed data memory bus between the MEM-stage sequencer and memory.
// Ports: master drives MemReq/MemWe/MemAddr/MemBE/MemWData; slave returns MemAck/MemRData.
interface mem_access_unit_if #(
    parameter int ADDR_W = 30
) ();
    logic              MemReq;
    logic              MemWe;
    logic [ADDR_W-1:0] MemAddr;
    logic [3:0]        MemBE;
    logic [31:0]       MemWData;
    logic              MemAck;
    logic [31:0]       MemRData;

    modport master (
        output MemReq, MemWe, MemAddr, MemBE, MemWData,
        input  MemAck, MemRData
    );

    modport slave (
        input  MemReq, MemWe, MemAddr, MemBE, MemWData,
        output MemAck, MemRData
    );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store sequencer: aligns stores, runs req/ack, stalls, returns raw load word.
// Ports: clk, rst_n, pipeline request (ReqValid/ReqReady/Addr/StoreData/LoadType/StoreType),
// StallM, mem bus (master modport), WB response (RespValid/RdWord/LoadedBytesSelect/RegWriteW/errors).
module mem_access_unit #(
    parameter int ADDR_W         = 30,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ReqValid,
    output logic        ReqReady,
    input  logic [31:0] Addr,
    input  logic [31:0] StoreData,
    input  logic [2:0]  LoadType,
    input  logic [1:0]  StoreType,
    output logic        StallM,
    mem_access_unit_if.master mem,
    output logic        RespValid,
    output logic [31:0] RdWord,
    output logic [1:0]  LoadedBytesSelect,
    output logic [2:0]  RegWriteW,
    output logic        MisalignErr,
    output logic        BusErr
);
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] TO_LAST =
        CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t        state;
    logic [CW-1:0] tcnt;
    logic [2:0]    ld_type;
    logic [1:0]    sel;

    logic        is_store;
    logic        is_load;
    logic        mis;
    logic [3:0]  be;
    logic [31:0] wd;
    logic        timeout;

    assign ReqReady = (state == IDLE);
    assign StallM   = (state != IDLE) | ReqValid;
    assign timeout  = (TIMEOUT_CYCLES != 0) && (tcnt == TO_LAST);

    always_comb begin
        is_store = (StoreType != 2'd0);
        is_load  = !is_store && (LoadType != 3'd0);
        mis      = 1'b0;
        be       = 4'b1111;
        wd       = 32'd0;
        if (is_store) begin
            unique case (StoreType)
                2'd1: begin
                    wd = {4{StoreData[7:0]}};
                    be = 4'b0001 << Addr[1:0];
                end
                2'd2: begin
                    wd  = {2{StoreData[15:0]}};
                    be  = Addr[1] ? 4'b1100 : 4'b0011;
                    mis = Addr[0];
                end
                default: begin
                    wd  = StoreData;
                    mis = |Addr[1:0];
                end
            endcase
        end else begin
            unique case (LoadType)
                3'd2, 3'd5: mis = Addr[0];
                3'd3:       mis = |Addr[1:0];
                default:    mis = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            tcnt              <= '0;
            ld_type           <= 3'd0;
            sel               <= 2'd0;
            mem.MemReq        <= 1'b0;
            mem.MemWe         <= 1'b0;
            mem.MemAddr       <= '0;
            mem.MemBE         <= 4'd0;
            mem.MemWData      <= 32'd0;
            RespValid         <= 1'b0;
            RdWord            <= 32'd0;
            LoadedBytesSelect <= 2'd0;
            RegWriteW         <= 3'd0;
            MisalignErr       <= 1'b0;
            BusErr            <= 1'b0;
        end else begin
            RespValid   <= 1'b0;
            MisalignErr <= 1'b0;
            BusErr      <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (ReqValid && (is_store || is_load)) begin
                        mem.MemAddr  <= Addr[ADDR_W+1:2];
                        mem.MemBE    <= be;
                        mem.MemWData <= wd;
                        mem.MemWe    <= is_store;
                        ld_type      <= is_store ? 3'd0 : LoadType;
                        sel          <= Addr[1:0];
                        tcnt         <= '0;
                        if (mis) begin
                            // No bus cycle: report the fault straight away.
                            state             <= DONE;
                            RespValid         <= 1'b1;
                            MisalignErr       <= 1'b1;
                            RegWriteW         <= 3'd0;
                            RdWord            <= 32'd0;
                            LoadedBytesSelect <= Addr[1:0];
                        end else begin
                            state      <= WAIT;
                            mem.MemReq <= 1'b1;
                        end
                    end
                end
                WAIT: begin
                    // An ack in the timeout cycle still completes normally.
                    if (mem.MemAck) begin
                        state             <= DONE;
                        mem.MemReq        <= 1'b0;
                        RespValid         <= 1'b1;
                        RegWriteW         <= ld_type;
                        LoadedBytesSelect <= sel;
                        if (!mem.MemWe) begin
                            RdWord <= mem.MemRData;
                        end
                    end else if (timeout) begin
                        state             <= DONE;
                        mem.MemReq        <= 1'b0;
                        RespValid         <= 1'b1;
                        BusErr            <= 1'b1;
                        RdWord            <= 32'd0;
                        RegWriteW         <= 3'd0;
                        LoadedBytesSelect <= sel;
                    end else begin
                        tcnt <= tcnt + CW'(1);
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
